// File: rtl/sha_last_pipelined_nonce_scheduler_pkg.sv
// Shared definitions for the double-SHA-256 nonce scheduler.
package sha_last_pipelined_nonce_scheduler_pkg;

  // Scheduler phases: waiting for work, issuing nonces, draining the pipe, reporting.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } SchedState;

  // Stage count of the super-pipelined core through the last pad/hash stage.
  localparam int unsigned DEFAULT_PIPE_DEPTH = 134;

endpackage

// File: rtl/sha_last_pipelined_nonce_scheduler.sv
// Nonce scheduler at the head of the double-SHA-256 pipeline: accepts one work
// unit, issues one nonce per cycle, then waits out the pipeline drain.
module sha_last_pipelined_nonce_scheduler
  import sha_last_pipelined_nonce_scheduler_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = DEFAULT_PIPE_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        work_valid_i,
  output logic        work_ready_o,
  input  logic [31:0] nonce_start_i,
  input  logic [31:0] nonce_count_i,
  input  logic        hold_i,
  input  logic        abort_i,
  output logic        valid_o,
  output logic        newblock_o,
  output logic [31:0] nonce_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned           DRAIN_W    = $clog2(PIPE_DEPTH + 1);
  localparam logic [DRAIN_W-1:0]    DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH);
  localparam logic [DRAIN_W-1:0]    DRAIN_ONE  = DRAIN_W'(1);

  SchedState           state_q, state_d;
  logic [31:0]         cur_q, cur_d;
  logic [31:0]         rem_q, rem_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic                pend_q, pend_d;
  logic                valid_q, valid_d;
  logic                newblock_q, newblock_d;
  logic [31:0]         nonce_q, nonce_d;
  logic                done_q, done_d;

  logic                load;
  logic                cont;
  logic                issue;
  logic [31:0]         src_cur;
  logic [31:0]         src_rem;
  logic                src_pend;

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      rem_q      <= '0;
      drain_q    <= '0;
      pend_q     <= 1'b0;
      valid_q    <= 1'b0;
      newblock_q <= 1'b0;
      nonce_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      drain_q    <= drain_d;
      pend_q     <= pend_d;
      valid_q    <= valid_d;
      newblock_q <= newblock_d;
      nonce_q    <= nonce_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic and drain countdown.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (work_valid_i) begin
          state_d = (nonce_count_i == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        // rem_q counts nonces still to issue, so zero here means the final
        // issue is already on valid_o; an abort in the same cycle is identical.
        if (rem_q == '0 || abort_i) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (drain_q <= DRAIN_ONE) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - DRAIN_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  // Nonce issue: the registered outputs of cycle t+1 are decided from hold_i of cycle t.
  always_comb begin
    load     = (state_q == IDLE) && work_valid_i && (nonce_count_i != '0);
    cont     = (state_q == ISSUE) && (rem_q != '0) && !abort_i;
    issue    = (load || cont) && !hold_i;
    src_cur  = load ? nonce_start_i : cur_q;
    src_rem  = load ? nonce_count_i : rem_q;
    src_pend = load || pend_q;

    cur_d      = src_cur;
    rem_d      = src_rem;
    pend_d     = src_pend;
    valid_d    = 1'b0;
    newblock_d = 1'b0;
    nonce_d    = nonce_q;
    if (issue) begin
      valid_d    = 1'b1;
      nonce_d    = src_cur;
      newblock_d = src_pend;
      cur_d      = src_cur + 32'd1;
      rem_d      = src_rem - 32'd1;
      pend_d     = 1'b0;
    end
  end

  // Output decode from the state register and registered issue signals.
  always_comb begin
    work_ready_o = (state_q == IDLE);
    busy_o       = (state_q == ISSUE) || (state_q == DRAIN);
    valid_o      = valid_q;
    newblock_o   = newblock_q;
    nonce_o      = nonce_q;
    done_o       = done_q;
  end

endmodule

// File: tb/tb_sha_last_pipelined_nonce_scheduler.sv
// Randomised self-checking bench for the nonce scheduler (PIPE_DEPTH=4).
module tb_sha_last_pipelined_nonce_scheduler;

  localparam int PD   = 4;
  localparam int MAXC = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        work_valid_i = 1'b0;
  logic        work_ready_o;
  logic [31:0] nonce_start_i = '0;
  logic [31:0] nonce_count_i = '0;
  logic        hold_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        valid_o;
  logic        newblock_o;
  logic [31:0] nonce_o;
  logic        busy_o;
  logic        done_o;

  int total = 0;
  int bad   = 0;
  int unit_no = 0;

  // Per-unit stimulus and expected outputs, indexed by cycle relative to accept.
  bit          hold_a [MAXC];
  bit          abort_a[MAXC];
  bit          ev     [MAXC];
  bit          enb    [MAXC];
  bit          ebusy  [MAXC];
  bit          edone  [MAXC];
  bit          erdy   [MAXC];
  logic [31:0] enon   [MAXC];
  int          end_k;

  sha_last_pipelined_nonce_scheduler #(.PIPE_DEPTH(PD)) dut (
    .clk           (clk),
    .rst           (rst),
    .work_valid_i  (work_valid_i),
    .work_ready_o  (work_ready_o),
    .nonce_start_i (nonce_start_i),
    .nonce_count_i (nonce_count_i),
    .hold_i        (hold_i),
    .abort_i       (abort_i),
    .valid_o       (valid_o),
    .newblock_o    (newblock_o),
    .nonce_o       (nonce_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      hold_a[i]  = 1'b0;
      abort_a[i] = 1'b0;
    end
  endfunction

  // Reference: cycle k issues when hold was low in k-1 and nonces remain; once
  // all are issued or an abort is seen, PD drain cycles follow, then one done cycle.
  function automatic void build(input logic [31:0] start, input logic [31:0] n);
    int          d;
    int          k;
    int unsigned issued;
    bit          nb;
    for (int i = 0; i < MAXC; i++) begin
      ev[i] = 0; enb[i] = 0; ebusy[i] = 0; edone[i] = 0; erdy[i] = 0; enon[i] = '0;
    end
    erdy[0] = 1'b1;
    if (n == 0) begin
      edone[1] = 1'b1;
      end_k    = 2;
    end else begin
      issued = 0;
      nb     = 1'b1;
      d      = 0;
      k      = 1;
      while (d == 0 && k < MAXC - PD - 2) begin
        ebusy[k] = 1'b1;
        if (!hold_a[k-1] && issued < n) begin
          ev[k]   = 1'b1;
          enon[k] = start + issued;
          enb[k]  = nb;
          nb      = 1'b0;
          issued++;
        end
        if (issued == n || abort_a[k]) d = k + 1;
        k++;
      end
      if (d == 0) d = k;
      for (int j = d; j < d + PD; j++) ebusy[j] = 1'b1;
      edone[d + PD] = 1'b1;
      end_k = d + PD + 1;
    end
  endfunction

  // Runs one unit starting in an IDLE cycle; returns in the cycle ready reasserts.
  task automatic run_unit(input logic [31:0] start, input logic [31:0] n);
    build(start, n);
    unit_no++;
    for (int k = 0; k < end_k; k++) begin
      chk($sformatf("u%0d.ready@%0d", unit_no, k), work_ready_o, erdy[k]);
      chk($sformatf("u%0d.valid@%0d", unit_no, k), valid_o, ev[k]);
      chk($sformatf("u%0d.newblock@%0d", unit_no, k), newblock_o, enb[k]);
      chk($sformatf("u%0d.busy@%0d", unit_no, k), busy_o, ebusy[k]);
      chk($sformatf("u%0d.done@%0d", unit_no, k), done_o, edone[k]);
      if (ev[k]) chk($sformatf("u%0d.nonce@%0d", unit_no, k), nonce_o, enon[k]);
      work_valid_i  = 1'b1;
      nonce_start_i = (k == 0) ? start : $urandom;
      nonce_count_i = (k == 0) ? n : $urandom_range(0, 50);
      hold_i        = hold_a[k];
      abort_i       = abort_a[k];
      @(posedge clk);
      #1;
    end
    work_valid_i = 1'b0;
    hold_i       = 1'b0;
    abort_i      = 1'b0;
  endtask

  initial begin
    logic [31:0] s;
    logic [31:0] n;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", work_ready_o, 1);
    chk("rst.valid", valid_o, 0);
    chk("rst.newblock", newblock_o, 0);
    chk("rst.nonce", nonce_o, 0);
    chk("rst.busy", busy_o, 0);
    chk("rst.done", done_o, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    clear_stim();
    run_unit(32'h0000_0010, 32'd3);
    clear_stim();
    run_unit(32'hFFFF_FFFE, 32'd4);
    clear_stim();
    hold_a[0] = 1'b1;
    hold_a[1] = 1'b1;
    run_unit(32'h0000_1000, 32'd5);
    clear_stim();
    abort_a[2] = 1'b1;
    run_unit(32'h0000_2000, 32'd100);
    clear_stim();
    run_unit(32'h0000_3000, 32'd0);

    // Reset in the middle of issuing a unit.
    work_valid_i  = 1'b1;
    nonce_start_i = 32'h0000_0055;
    nonce_count_i = 32'd10;
    @(posedge clk);
    #1;
    work_valid_i = 1'b0;
    chk("mid.valid", valid_o, 1);
    chk("mid.nonce", nonce_o, 32'h0000_0055);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.ready", work_ready_o, 1);
    chk("arst.valid", valid_o, 0);
    chk("arst.newblock", newblock_o, 0);
    chk("arst.nonce", nonce_o, 0);
    chk("arst.busy", busy_o, 0);
    chk("arst.done", done_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int u = 0; u < 30; u++) begin
      clear_stim();
      n = $urandom_range(0, 20);
      s = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
      for (int k = 0; k < 40; k++) hold_a[k] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) abort_a[$urandom_range(0, 25)] = 1'b1;
      run_unit(s, n);
    end

    chk("end.ready", work_ready_o, 1);
    chk("end.busy", busy_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
